// File: rtl/sd4_weight_encoder.sv
// Converts raw two's-complement weight words into packed radix-4 Booth (SD4) words for the PE.
// Optional SD4_ZERO_SKIP_EN: all-zero words are dropped instead of issued and counted in skip_cnt.
module sd4_weight_encoder #(
    parameter int LANES  = 4,
    parameter int WBITS  = 6,
    parameter int SKIP_W = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           w_valid,
    output logic                           w_ready,
    input  logic [LANES*WBITS-1:0]         w_data,
    input  logic [4:0]                     w_exp_bias,
    input  logic                           pe_busy,
    output logic                           en,
    output logic [LANES*(WBITS/2)*3-1:0]   weight_out,
    output logic [4:0]                     exp_bias_out,
    output logic [SKIP_W-1:0]              skip_cnt
);

    localparam int ND = WBITS / 2;
    localparam int LW = ND * 3;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        ISSUE
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic [LANES*WBITS-1:0]   raw_word;
    logic [4:0]               bias_q;
    logic [LANES*LW-1:0]      staging;
    logic [CW-1:0]            cnt;
    logic [WBITS-1:0]         lane_raw;
    logic [LW-1:0]            lane_digits;
    logic                     accept;
    logic                     do_issue;
    logic                     do_skip;

    // Each digit looks at bits {x[2j+1], x[2j], x[2j-1]}; a zero appended below bit 0 supplies x[-1].
    function automatic logic [LW-1:0] encode_lane(input logic [WBITS-1:0] x);
        logic [WBITS:0]  xe;
        logic [2:0]      bits;
        logic [2:0]      dg;
        logic [LW-1:0]   r;
        xe = {x, 1'b0};
        r  = '0;
        for (int j = 0; j < ND; j++) begin
            bits = xe[2*j +: 3];
            case (bits)
                3'b001, 3'b010: dg = 3'b001;
                3'b011:         dg = 3'b010;
                3'b100:         dg = 3'b110;
                3'b101, 3'b110: dg = 3'b101;
                default:        dg = 3'b000;
            endcase
            r[3*j +: 3] = dg;
        end
        return r;
    endfunction

    always_comb begin
        lane_raw = '0;
        for (int i = 0; i < LANES; i++) begin
            if (cnt == CW'(i)) lane_raw = raw_word[i*WBITS +: WBITS];
        end
    end

    assign lane_digits = encode_lane(lane_raw);

    always_comb begin
        next_state = state;
        w_ready    = 1'b0;
        accept     = 1'b0;
        do_issue   = 1'b0;
        do_skip    = 1'b0;
        case (state)
            IDLE: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    accept     = 1'b1;
                    next_state = ENC;
                end
            end
            ENC: begin
                if (cnt == CW'(LANES - 1)) next_state = ISSUE;
            end
            ISSUE: begin
`ifdef SD4_ZERO_SKIP_EN
                if (staging == '0) begin
                    do_skip    = 1'b1;
                    next_state = IDLE;
                end else if (!pe_busy) begin
                    do_issue   = 1'b1;
                    next_state = IDLE;
                end
`else
                if (!pe_busy) begin
                    do_issue   = 1'b1;
                    next_state = IDLE;
                end
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // en is registered so it is a clean single-cycle pulse alongside the new weight_out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            raw_word     <= '0;
            bias_q       <= '0;
            staging      <= '0;
            cnt          <= '0;
            en           <= 1'b0;
            weight_out   <= '0;
            exp_bias_out <= '0;
        end else begin
            en <= do_issue;
            if (accept) begin
                raw_word <= w_data;
                bias_q   <= w_exp_bias;
                cnt      <= '0;
            end
            if (state == ENC) begin
                for (int i = 0; i < LANES; i++) begin
                    if (cnt == CW'(i)) staging[i*LW +: LW] <= lane_digits;
                end
                cnt <= cnt + 1'b1;
            end
            if (do_issue) begin
                weight_out   <= staging;
                exp_bias_out <= bias_q;
            end
        end
    end

`ifdef SD4_ZERO_SKIP_EN
    always_ff @(posedge clk) begin
        if (!rst)                            skip_cnt <= '0;
        else if (do_skip && skip_cnt != '1)  skip_cnt <= skip_cnt + 1'b1;
    end
`else
    assign skip_cnt = '0;
    logic unused_skip;
    assign unused_skip = do_skip;
`endif

endmodule
